// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer: 2-input Galois MISR response compactor with golden-signature compare; BIST_XMASK_EN adds test_mask X-masking.
module bist_response_analyzer #(
    parameter int                MISR_W       = 16,
    parameter logic [MISR_W-1:0] POLY         = 16'h1021,
    parameter logic [MISR_W-1:0] SEED         = 16'hFFFF,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = 16'h0000,
    parameter int                NUM_CAPTURES = 32,
    parameter int                CNT_W        = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bist_start,
    input  logic              capture_en,
    input  logic [1:0]        test_out,
`ifdef BIST_XMASK_EN
    input  logic [1:0]        test_mask,
`endif
    output logic              pass_nfail,
    output logic              bist_end,
    output logic              busy,
    output logic [MISR_W-1:0] signature
);
    typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;
    state_t            state;
    logic              bist_start_q;
    logic [CNT_W-1:0]  count;
    logic [1:0]        data;
    logic              start_edge;
    logic [MISR_W-1:0] misr_next;
`ifdef BIST_XMASK_EN
    assign data = test_out & ~test_mask;
`else
    assign data = test_out;
`endif
    assign start_edge = bist_start & ~bist_start_q;
    assign misr_next  = {signature[MISR_W-2:0], 1'b0} ^ (signature[MISR_W-1] ? POLY : '0)
                      ^ {{(MISR_W-2){1'b0}}, data};
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            bist_start_q <= 1'b0;
            signature    <= SEED;
            count        <= '0;
            pass_nfail   <= 1'b0;
            bist_end     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            bist_start_q <= bist_start;
            case (state)
                IDLE: if (start_edge) begin
                    signature  <= SEED;
                    count      <= '0;
                    pass_nfail <= 1'b0;
                    bist_end   <= 1'b0;
                    busy       <= 1'b1;
                    state      <= COMPACT;
                end
                // an abort wins over a coincident capture so the signature stays frozen for debug
                COMPACT: if (!bist_start) begin
                    pass_nfail <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end else if (capture_en) begin
                    signature <= misr_next;
                    count     <= count + 1'b1;
                    if (count == CNT_W'(NUM_CAPTURES - 1)) state <= COMPARE;
                end
                COMPARE: if (!bist_start) begin
                    pass_nfail <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end else begin
                    pass_nfail <= (signature == GOLDEN_SIG);
                    bist_end   <= 1'b1;
                    busy       <= 1'b0;
                    state      <= DONE;
                end
                default: if (!bist_start) begin
                    bist_end <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb_bist_response_analyzer: directed checks of MISR stepping, compare, gaps, abort and reset.
module tb_bist_response_analyzer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bist_start = 1'b0;
    logic        capture_en = 1'b0;
    logic [1:0]  test_out = 2'b00;
    logic [1:0]  test_mask = 2'b00;
    logic        pass_nfail, bist_end, busy;
    logic [15:0] signature;
    int          vectors = 0;
    int          miscompares = 0;

    bist_response_analyzer #(.NUM_CAPTURES(4), .GOLDEN_SIG(16'h0E1F)) dut (
        .clock(clock), .reset(reset), .bist_start(bist_start), .capture_en(capture_en),
        .test_out(test_out),
`ifdef BIST_XMASK_EN
        .test_mask(test_mask),
`endif
        .pass_nfail(pass_nfail), .bist_end(bist_end), .busy(busy), .signature(signature));

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [15:0] sig, input logic p, input logic e, input logic b);
        vectors++;
        if (signature !== sig || pass_nfail !== p || bist_end !== e || busy !== b) begin
            miscompares++;
            $display("FAIL %s: got sig=%h pass=%b end=%b busy=%b, want sig=%h pass=%b end=%b busy=%b",
                     name, signature, pass_nfail, bist_end, busy, sig, p, e, b);
        end
    endtask

    task automatic capture(input logic [1:0] d, input logic [15:0] exp, input string name);
        capture_en = 1'b1;
        test_out   = d;
        tick();
        capture_en = 1'b0;
        test_out   = 2'b00;
        vectors++;
        if (signature !== exp) begin
            miscompares++;
            $display("FAIL %s: got sig=%h want %h", name, signature, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        check_outs("reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pass;
        bist_start = 1'b1;
        tick();
        check_outs("pass_start", 16'hFFFF, 1'b0, 1'b0, 1'b1);
        capture(2'b00, 16'hEFDF, "pass_cap1");
        capture(2'b00, 16'hCF9F, "pass_cap2");
        capture(2'b00, 16'h8F1F, "pass_cap3");
        capture(2'b00, 16'h0E1F, "pass_cap4");
        check_outs("pass_not_yet", 16'h0E1F, 1'b0, 1'b0, 1'b1);
        tick(2);
        check_outs("pass_done", 16'h0E1F, 1'b1, 1'b1, 1'b0);
        bist_start = 1'b0;
        tick();
        check_outs("pass_release", 16'h0E1F, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_fail;
        bist_start = 1'b1;
        tick();
        check_outs("fail_start", 16'hFFFF, 1'b0, 1'b0, 1'b1);
        capture(2'b00, 16'hEFDF, "fail_cap1");
        capture(2'b01, 16'hCF9E, "fail_cap2");
        capture(2'b00, 16'h8F1D, "fail_cap3");
        capture(2'b00, 16'h0E1B, "fail_cap4");
        tick(2);
        check_outs("fail_done", 16'h0E1B, 1'b0, 1'b1, 1'b0);
        bist_start = 1'b0;
        tick();
    endtask

    task automatic test_gaps;
        capture_en = 1'b1;
        test_out   = 2'b11;
        tick();
        check_outs("gap_idle_cap", 16'h0E1B, 1'b0, 1'b0, 1'b0);
        bist_start = 1'b1;
        tick();
        capture_en = 1'b0;
        test_out   = 2'b00;
        check_outs("gap_start_cap", 16'hFFFF, 1'b0, 1'b0, 1'b1);
        tick(2);
        capture(2'b00, 16'hEFDF, "gap_cap1");
        tick(2);
        check_outs("gap_hold", 16'hEFDF, 1'b0, 1'b0, 1'b1);
        capture(2'b00, 16'hCF9F, "gap_cap2");
        tick(2);
        capture(2'b00, 16'h8F1F, "gap_cap3");
        tick(2);
        capture(2'b00, 16'h0E1F, "gap_cap4");
        tick();
        capture_en = 1'b1;
        test_out   = 2'b11;
        tick(3);
        capture_en = 1'b0;
        test_out   = 2'b00;
        check_outs("gap_done_caps", 16'h0E1F, 1'b1, 1'b1, 1'b0);
        bist_start = 1'b0;
        tick();
    endtask

    task automatic test_abort;
        bist_start = 1'b1;
        tick();
        capture(2'b00, 16'hEFDF, "abort_cap1");
        capture(2'b00, 16'hCF9F, "abort_cap2");
        bist_start = 1'b0;
        tick();
        check_outs("abort_idle", 16'hCF9F, 1'b0, 1'b0, 1'b0);
        tick();
        bist_start = 1'b1;
        tick();
        check_outs("abort_reseed", 16'hFFFF, 1'b0, 1'b0, 1'b1);
        capture(2'b00, 16'hEFDF, "restart_cap1");
        capture(2'b00, 16'hCF9F, "restart_cap2");
        capture(2'b00, 16'h8F1F, "restart_cap3");
        capture(2'b00, 16'h0E1F, "restart_cap4");
        tick(2);
        check_outs("restart_done", 16'h0E1F, 1'b1, 1'b1, 1'b0);
        bist_start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        bist_start = 1'b1;
        tick();
        capture(2'b00, 16'hEFDF, "rmid_cap1");
        capture(2'b00, 16'hCF9F, "rmid_cap2");
        reset      = 1'b1;
        bist_start = 1'b0;
        tick();
        check_outs("rmid_reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
        check_outs("rmid_idle", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef BIST_XMASK_EN
    task automatic test_mask_feature;
        bist_start = 1'b1;
        test_mask  = 2'b11;
        tick();
        capture(2'b11, 16'hEFDF, "mask_cap1");
        capture(2'b11, 16'hCF9F, "mask_cap2");
        capture(2'b11, 16'h8F1F, "mask_cap3");
        capture(2'b11, 16'h0E1F, "mask_cap4");
        tick(2);
        check_outs("mask_done", 16'h0E1F, 1'b1, 1'b1, 1'b0);
        bist_start = 1'b0;
        test_mask  = 2'b00;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_gaps();
        test_abort();
        test_reset_mid();
`ifdef BIST_XMASK_EN
        test_mask_feature();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
